// File: rtl/nibble_serial_addsub.sv
// Nibble-serial adder/subtractor.
// A single 4-bit adder slice processes one nibble per cycle, LSB first.
// Operands are captured on accept, so the requester may change its inputs
// while the operation is running. The result is held under backpressure
// until the consumer takes it.
// WIDTH must be a multiple of 4 and at least 8.

module full_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       invert_b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);

    logic [3:0] b_eff;

    // Subtraction is A + ~B + 1; the +1 comes in through c_in on the first nibble.
    assign b_eff        = b ^ {4{invert_b}};
    assign {c_out, sum} = {1'b0, a} + {1'b0, b_eff} + {4'b0000, c_in};

endmodule

module nibble_serial_addsub #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             busy
);

    localparam int NSTEP = WIDTH / 4;
    localparam int SW    = $clog2(NSTEP);

    localparam logic [SW-1:0] LAST_STEP = SW'(NSTEP - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sub_q;
    logic [SW-1:0]    step_q;
    logic             carry_q;
    logic [WIDTH-1:0] result_q;

    // Bit offset of the current nibble. clog2(4*NSTEP) == SW+2, so the width is exact.
    logic [SW+1:0]    bit_base;
    logic [3:0]       slice_sum;
    logic             slice_cout;

    assign bit_base = {step_q, 2'b00};

    full_adder_4bit u_slice (
        .a        (a_q[bit_base +: 4]),
        .b        (b_q[bit_base +: 4]),
        .invert_b (sub_q),
        .c_in     (carry_q),
        .sum      (slice_sum),
        .c_out    (slice_cout)
    );

    // Control FSM and datapath: accept in IDLE, one nibble per RUN cycle, hold in DONE.
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples its pre-edge value, whatever order the statements are in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            step_q   <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        a_q     <= op_a;
                        b_q     <= op_b;
                        sub_q   <= sub;
                        step_q  <= '0;
                        carry_q <= sub;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    result_q[bit_base +: 4] <= slice_sum;
                    carry_q                 <= slice_cout;
                    // Hold at the last step instead of wrapping; accept clears it anyway.
                    if (step_q == LAST_STEP) begin
                        state_q <= DONE;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign start_ready  = (state_q == IDLE);
    assign result_valid = (state_q == DONE);
    assign busy         = (state_q == RUN) || (state_q == DONE);
    assign result       = result_q;

    // Flags are meaningful only while a result is presented; they are forced low otherwise.
    assign carry_out = result_valid & carry_q;
    assign overflow  = result_valid
                     & (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ sub_q))
                     & (result_q[WIDTH-1] != a_q[WIDTH-1]);
    assign zero      = result_valid & (result_q == '0);

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Self-checking bench for nibble_serial_addsub (WIDTH = 32).
// The driver pushes hand-computed expectations into a queue. A monitor pops
// an entry and compares it on every result handshake.

module tb_nibble_serial_addsub;

    localparam int WIDTH = 32;

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        z;
        string       tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             sub;
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             busy;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    nibble_serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .sub          (sub),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .carry_out    (carry_out),
        .overflow     (overflow),
        .zero         (zero),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compare against the oldest expectation on every result handshake.
    always @(negedge clk) begin
        if (!rst && result_valid && result_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'(result), 64'hDEAD_BEEF_0000_0000);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.tag, "_result"},   64'(result),    64'(e.res));
                check({e.tag, "_carry"},    64'(carry_out), 64'(e.c));
                check({e.tag, "_overflow"}, 64'(overflow),  64'(e.v));
                check({e.tag, "_zero"},     64'(zero),      64'(e.z));
            end
        end
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operation and return just after its accept edge, with the inputs scrambled.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        int n;
        n = 0;
        while (!start_ready && n < 50) begin
            tick();
            n++;
        end
        check("ready_before_issue", 64'(start_ready), 64'd1);
        start_valid = 1'b1;
        op_a        = a;
        op_b        = b;
        sub         = s;
        tick();
        start_valid = 1'b0;
        op_a        = $urandom;
        op_b        = $urandom;
        sub         = 1'($urandom_range(0, 1));
        check("busy_after_accept", 64'(busy), 64'd1);
    endtask

    // Count edges from the accept edge until result_valid is seen, bounded.
    task automatic wait_result(input string tag);
        int n;
        n = 1;
        while (!result_valid && n < 40) begin
            tick();
            n++;
        end
        n--;
        check({tag, "_latency"}, 64'(n), 64'd8);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] r, input logic c,
                          input logic v, input logic z);
        exp_t e;
        e.res = r; e.c = c; e.v = v; e.z = z; e.tag = tag;
        exp_q.push_back(e);
        issue(a, b, s);
        check({tag, "_ready_in_run"}, 64'(start_ready), 64'd0);
        wait_result(tag);
        tick();  // handshake edge; result_ready is already high
    endtask

    initial begin
        exp_t e;
        int   n;

        rst          = 1'b1;
        start_valid  = 1'b0;
        op_a         = '0;
        op_b         = '0;
        sub          = 1'b0;
        result_ready = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_start_ready",  64'(start_ready),  64'd1);
        check("rst_result_valid", 64'(result_valid), 64'd0);
        check("rst_busy",         64'(busy),         64'd0);
        check("rst_result",       64'(result),       64'd0);
        check("rst_carry",        64'(carry_out),    64'd0);
        check("rst_overflow",     64'(overflow),     64'd0);
        check("rst_zero",         64'(zero),         64'd0);
        rst = 1'b0;
        tick();

        // Directed vectors: tag, a, b, sub, result, carry, overflow, zero
        run_op("add_pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_op("add_wrap",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_op("sub_equal",   32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_op("sub_borrow",  32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_neg_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_op("sub_chain",   32'h1000_0000, 32'h0000_0001, 1'b1, 32'h0FFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_op("add_mixed",   32'h89AB_CDEF, 32'h7654_3211, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

        // Backpressure: result held while result_ready low and start_valid toggles
        result_ready = 1'b0;
        e.res = 32'h2345_6789; e.c = 1'b0; e.v = 1'b0; e.z = 1'b0; e.tag = "bp_hold";
        exp_q.push_back(e);
        issue(32'h1234_5678, 32'h1111_1111, 1'b0);
        wait_result("bp_hold");
        for (int i = 0; i < 20; i++) begin
            start_valid = 1'b1;
            op_a        = $urandom;
            op_b        = $urandom;
            sub         = 1'(i & 1);
            tick();
            check("bp_result",      64'(result),       64'h2345_6789);
            check("bp_valid",       64'(result_valid), 64'd1);
            check("bp_start_ready", 64'(start_ready),  64'd0);
            check("bp_flags",       64'({carry_out, overflow, zero}), 64'd0);
        end
        // Release, with the next operation already presented
        op_a  = 32'h0000_0010;
        op_b  = 32'h0000_0020;
        sub   = 1'b0;
        e.res = 32'h0000_0030; e.c = 1'b0; e.v = 1'b0; e.z = 1'b0; e.tag = "bp_next";
        exp_q.push_back(e);
        result_ready = 1'b1;
        tick();
        check("rel_start_ready", 64'(start_ready),  64'd1);
        check("rel_valid",       64'(result_valid), 64'd0);
        tick();
        check("rel_accepted",    64'(busy),         64'd1);
        start_valid = 1'b0;
        op_a        = 32'hFFFF_FFFF;
        op_b        = 32'hFFFF_FFFF;
        wait_result("bp_next");
        tick();

        // Reset at RUN step 3 discards the in-flight operation
        issue(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
        tick();
        tick();
        tick();
        rst         = 1'b1;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        rst         = 1'b0;
        check("mid_rst_valid",  64'(result_valid), 64'd0);
        check("mid_rst_result", 64'(result),       64'd0);
        check("mid_rst_ready",  64'(start_ready),  64'd1);
        check("mid_rst_busy",   64'(busy),         64'd0);
        run_op("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("pending_results", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
